// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO over a valid/ready handshake.
// Bytes leave LSB-first on a registered line; frames run back-to-back while the FIFO has data.
module uart_tx_fifo #(
    parameter int CLK_FREQ_HZ = 30000000,
    parameter int BAUD_RATE   = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_valid,
    input  logic [7:0]                    i_data,
    output logic                          o_ready,
    output logic                          o_uart_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BAUD_ONE   = CNT_W'(1);
    localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_push;
    logic w_pop;
    logic w_fifo_empty;
    logic w_baud_done;

    // Handshake: a byte transfers on every rising edge where i_valid && o_ready.
    assign o_ready      = (r_count != COUNT_FULL);
    assign w_push       = i_valid && o_ready;
    assign w_fifo_empty = (r_count == '0);
    assign w_baud_done  = (r_baud_cnt == BAUD_LAST);
    assign w_pop        = !w_fifo_empty &&
                          ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_done));

    assign o_uart_tx    = r_tx;
    assign o_busy       = (r_state != S_IDLE);
    assign o_fifo_count = r_count;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + COUNT_ONE;
                2'b01:   r_count <= r_count - COUNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // The line value is registered alongside the state so o_uart_tx changes on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx       <= 1'b1;
                    r_baud_cnt <= '0;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_state    <= S_DATA;
                        r_tx       <= r_shift[0];
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_ONE;
                    end
                end
                S_DATA: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_ONE;
                    end
                end
                S_STOP: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        if (w_pop) begin
                            r_shift <= r_mem[r_rd_ptr];
                            r_state <= S_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_ONE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_baud_cnt <= '0;
                    r_tx       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level reference model, serial line decoder and directed corner sequences.
// Inputs change 2 ns after the rising edge; outputs are sampled on the falling edge or 1 ns after the rising edge.
module tb_uart_tx_fifo;

    localparam int CPB   = 10;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       i_clk   = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_valid = 1'b0;
    logic [7:0] i_data  = 8'h00;
    logic       o_ready;
    logic       o_uart_tx;
    logic       o_busy;
    logic [2:0] o_fifo_count;

    uart_tx_fifo #(
        .CLK_FREQ_HZ(1000000),
        .BAUD_RATE  (100000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .o_ready     (o_ready),
        .o_uart_tx   (o_uart_tx),
        .o_busy      (o_busy),
        .o_fifo_count(o_fifo_count)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            if (n_errors <= 40) begin
                $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
            end
        end
    endtask

    // Values the DUT saw at the most recent rising edge.
    bit         s_active = 1'b0;
    logic       s_valid  = 1'b0;
    logic [7:0] s_data   = 8'h00;
    always @(posedge i_clk) begin
        s_valid  <= i_valid;
        s_data   <= i_data;
        s_active <= i_rst_n;
    end

    // Reference model: queue of buffered bytes plus the frame currently on the line.
    logic [7:0] m_fifo[$];
    logic [7:0] exp_q[$];
    bit         m_in_frame = 1'b0;
    int         m_cyc      = 0;
    logic [7:0] m_cur      = 8'h00;

    always @(negedge i_clk) begin
        bit   pushed;
        bit   frame_end;
        bit   start_new;
        int   idx;
        logic exp_tx;
        if (!i_rst_n || !s_active) begin
            m_fifo.delete();
            exp_q.delete();
            m_in_frame = 1'b0;
            m_cyc      = 0;
        end else begin
            pushed    = s_valid && (m_fifo.size() != DEPTH);
            frame_end = m_in_frame && (m_cyc == FRAME - 1);
            start_new = (!m_in_frame || frame_end) && (m_fifo.size() != 0);
            if (start_new) begin
                m_cur      = m_fifo.pop_front();
                m_in_frame = 1'b1;
                m_cyc      = 0;
            end else if (m_in_frame) begin
                if (frame_end) m_in_frame = 1'b0;
                else           m_cyc++;
            end
            if (pushed) begin
                m_fifo.push_back(s_data);
                exp_q.push_back(s_data);
            end
            idx = m_cyc / CPB;
            if (!m_in_frame)  exp_tx = 1'b1;
            else if (idx == 0) exp_tx = 1'b0;
            else if (idx == 9) exp_tx = 1'b1;
            else               exp_tx = m_cur[idx-1];
            check("mon_tx", o_uart_tx, exp_tx);
            check("mon_busy", o_busy, m_in_frame);
            check("mon_count", o_fifo_count, m_fifo.size());
            check("mon_ready", o_ready, m_fifo.size() != DEPTH);
        end
    end

    // Serial receiver: finds the start bit and samples every bit at its centre.
    bit         d_active  = 1'b0;
    int         d_cnt     = 0;
    logic [7:0] d_byte    = 8'h00;
    int         n_decoded = 0;

    always @(negedge i_clk) begin
        if (!i_rst_n || !s_active) begin
            d_active = 1'b0;
            d_cnt    = 0;
        end else if (!d_active) begin
            if (o_uart_tx === 1'b0) begin
                d_active = 1'b1;
                d_cnt    = 0;
            end
        end else begin
            d_cnt++;
            if (d_cnt == 5) begin
                check("rx_start_bit", o_uart_tx, 1'b0);
            end else if (d_cnt >= 15 && d_cnt <= 85 && (d_cnt % 10) == 5) begin
                d_byte[(d_cnt - 15) / 10] = o_uart_tx;
            end else if (d_cnt == 95) begin
                check("rx_stop_bit", o_uart_tx, 1'b1);
                n_decoded++;
                check("rx_byte_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("rx_byte", d_byte, exp_q.pop_front());
                d_active = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge i_clk);
        #2;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(o_busy === 1'b0 && o_fifo_count === 3'd0) && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        check("wait_idle_in_budget", n < budget, 1'b1);
        step(1);
    endtask

    // Offers b and returns after the edge that accepts it, with i_valid still high.
    task automatic push_byte(input logic [7:0] b, output int waited);
        logic r;
        i_data  = b;
        i_valid = 1'b1;
        waited  = 0;
        forever begin
            @(negedge i_clk);
            r = o_ready;
            @(posedge i_clk);
            if (r === 1'b1) break;
            waited++;
            if (waited > 2000) begin
                check("push_accept_in_budget", 1'b0, 1'b1);
                break;
            end
        end
        #2;
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         w;
        int         n;
        int         lows;
        int         highs;
        int         dec_base;
        logic [7:0] six[6];
        logic       r;

        // line[i] is the i-th bit on the wire: start, d0..d7, stop.
        vecs[0] = '{data: 8'hA5, line: 10'h34A};
        vecs[1] = '{data: 8'h00, line: 10'h200};
        vecs[2] = '{data: 8'hFF, line: 10'h3FE};
        vecs[3] = '{data: 8'h3C, line: 10'h278};
        vecs[4] = '{data: 8'h81, line: 10'h302};

        repeat (3) @(posedge i_clk);
        #1;
        check("reset_tx", o_uart_tx, 1'b1);
        check("reset_ready", o_ready, 1'b1);
        check("reset_busy", o_busy, 1'b0);
        check("reset_count", o_fifo_count, 3'd0);
        #1;
        i_rst_n = 1'b1;
        step(2);

        // Single frames: line level at the centre of every bit and exact busy length.
        for (int v = 0; v < 5; v++) begin
            wait_idle(500);
            push_byte(vecs[v].data, w);
            i_valid = 1'b0;
            repeat (6) @(posedge i_clk);
            for (int i = 0; i < 10; i++) begin
                if (i > 0) repeat (CPB) @(posedge i_clk);
                #1;
                check($sformatf("vec%0d_bit%0d", v, i), o_uart_tx, vecs[v].line[i]);
                check($sformatf("vec%0d_busy%0d", v, i), o_busy, 1'b1);
            end
            n = 0;
            while (o_busy === 1'b1 && n < 50) begin
                @(posedge i_clk);
                #1;
                n++;
            end
            check($sformatf("vec%0d_busy_tail", v), n, 5);
            #1;
        end

        // Back-to-back frames with no idle gap.
        wait_idle(500);
        push_byte(8'h00, w);
        push_byte(8'hFF, w);
        i_valid = 1'b0;
        n = 0;
        while (n < 400) begin
            @(negedge i_clk);
            if (n == 0) check("b2b_count_after_second_push", o_fifo_count, 3'd1);
            if (o_busy !== 1'b1) break;
            n++;
        end
        check("b2b_busy_cycles", n, 2 * FRAME);
        step(1);

        // Held i_valid with six bytes: five accepted, sixth waits for the next pop.
        wait_idle(500);
        for (int j = 0; j < 6; j++) six[j] = 8'(8'h10 + 8'(j * 17));
        for (int j = 0; j < 5; j++) begin
            push_byte(six[j], w);
            check($sformatf("hold_accept%0d_no_wait", j), w, 0);
        end
        check("full_ready_low", o_ready, 1'b0);
        check("full_count", o_fifo_count, 3'd4);
        i_data = six[5];
        n = 0;
        forever begin
            @(negedge i_clk);
            r = o_ready;
            if (r === 1'b1) begin
                check("pop_edge_count_dropped", o_fifo_count, 3'd3);
                check("pop_edge_still_busy", o_busy, 1'b1);
            end
            @(posedge i_clk);
            if (r === 1'b1 || n > 500) break;
            n++;
        end
        check("sixth_wait_cycles", n, 97);
        #2;
        i_valid = 1'b0;
        check("sixth_accepted_count", o_fifo_count, 3'd4);
        check("sixth_accepted_ready", o_ready, 1'b0);
        wait_idle(1000);

        // Asynchronous reset in the middle of a frame with bytes queued.
        push_byte(8'h3C, w);
        push_byte(8'h11, w);
        push_byte(8'h22, w);
        i_valid = 1'b0;
        step(13);
        check("pre_reset_tx_low", o_uart_tx, 1'b0);
        check("pre_reset_count", o_fifo_count, 3'd2);
        check("pre_reset_busy", o_busy, 1'b1);
        #1;
        i_rst_n = 1'b0;
        #1;
        check("async_reset_tx", o_uart_tx, 1'b1);
        check("async_reset_busy", o_busy, 1'b0);
        check("async_reset_count", o_fifo_count, 3'd0);
        check("async_reset_ready", o_ready, 1'b1);
        repeat (3) @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
        lows  = 0;
        highs = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge i_clk);
            if (o_uart_tx !== 1'b1) lows++;
            if (o_busy !== 1'b0) highs++;
        end
        check("post_reset_line_low_cycles", lows, 0);
        check("post_reset_busy_cycles", highs, 0);
        step(1);

        // Random bytes at full rate, reproduced in order by the line decoder.
        dec_base = n_decoded;
        for (int j = 0; j < 256; j++) begin
            push_byte(8'($urandom_range(0, 255)), w);
        end
        i_valid = 1'b0;
        wait_idle(2000);
        step(2);
        check("random_decoded_count", n_decoded - dec_base, 256);
        check("exp_q_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
